// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int DEF_DATA_WIDTH = 8;

    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        clear,
    input  logic                        bit_en,
    input  logic [5:0]                  prescale,
    output logic [5:0]                  edge_count,
    output logic [$clog2(DATA_WIDTH):0] bit_count,
    output logic                        wrap
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    assign wrap = (edge_count == prescale - 6'd1);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else begin
            edge_count <= wrap ? 6'd0 : edge_count + 6'd1;
            // the bit index rolls back to 0 after the last data bit
            if (bit_en && wrap) begin
                if (bit_count == BW'(DATA_WIDTH - 1))
                    bit_count <= '0;
                else
                    bit_count <= bit_count + BW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: start detection, checker/deserializer
// enables and registered frame-result pulses.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        RxIn,
    input  logic [5:0]                  Prescale,
    input  logic                        ParityEnable,
    input  logic                        StartError,
    input  logic                        ParityError,
    input  logic                        StopError,
    output logic                        SampleEnable,
    output logic                        StartCheckEnable,
    output logic                        ParityCheckEnable,
    output logic                        StopCheckEnable,
    output logic                        DeserEnable,
    output logic [5:0]                  EdgeCount,
    output logic [$clog2(DATA_WIDTH):0] BitCount,
    output logic                        DataValid,
    output logic                        FrameError,
    output logic                        ParityFail
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    rx_state_e  state;
    rx_state_e  state_nx;
    logic [5:0] prescale_q;
    logic       parity_en_q;
    logic       fail_q;

    logic [5:0] half;
    logic       at_pre;
    logic       at_chk;
    logic       last_bit;
    logic       wrap;
    logic       cnt_clear;
    logic       bit_en;

    logic sample_d;
    logic start_d;
    logic par_d;
    logic stop_d;
    logic deser_d;
    logic valid_d;
    logic ferr_d;
    logic pfail_d;

    // enables are registered, so they are decided one edge before H
    assign half     = (prescale_q >> 1) + 6'd1;
    assign at_pre   = (EdgeCount == half - 6'd1);
    assign at_chk   = (EdgeCount == half + 6'd1);
    assign last_bit = (BitCount == BW'(DATA_WIDTH - 1));

    assign cnt_clear = (state == IDLE) || (state_nx == IDLE);
    assign bit_en    = (state == DATA);

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (cnt_clear),
        .bit_en     (bit_en),
        .prescale   (prescale_q),
        .edge_count (EdgeCount),
        .bit_count  (BitCount),
        .wrap       (wrap)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sample_d = 1'b0;
        start_d  = 1'b0;
        par_d    = 1'b0;
        stop_d   = 1'b0;
        deser_d  = 1'b0;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        pfail_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RxIn)
                    state_nx = START;
            end
            START: begin
                start_d = at_pre;
                if (at_chk && StartError)
                    state_nx = IDLE;
                else if (wrap)
                    state_nx = DATA;
            end
            DATA: begin
                deser_d = at_pre;
                if (wrap && last_bit)
                    state_nx = parity_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_d = at_pre;
                if (wrap)
                    state_nx = STOP;
            end
            STOP: begin
                stop_d = at_pre;
                // leave early so a back-to-back start is never missed
                if (at_chk) begin
                    state_nx = IDLE;
                    valid_d  = !StopError && !fail_q;
                    ferr_d   = StopError;
                    pfail_d  = fail_q && !StopError;
                end
            end
            default: state_nx = IDLE;
        endcase
        sample_d = (state_nx != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SampleEnable      <= 1'b0;
            StartCheckEnable  <= 1'b0;
            ParityCheckEnable <= 1'b0;
            StopCheckEnable   <= 1'b0;
            DeserEnable       <= 1'b0;
            DataValid         <= 1'b0;
            FrameError        <= 1'b0;
            ParityFail        <= 1'b0;
            prescale_q        <= PRESCALE_8;
            parity_en_q       <= 1'b0;
            fail_q            <= 1'b0;
        end else begin
            SampleEnable      <= sample_d;
            StartCheckEnable  <= start_d;
            ParityCheckEnable <= par_d;
            StopCheckEnable   <= stop_d;
            DeserEnable       <= deser_d;
            DataValid         <= valid_d;
            FrameError        <= ferr_d;
            ParityFail        <= pfail_d;
            if (state == IDLE && !RxIn) begin
                prescale_q  <= legal_prescale(Prescale);
                parity_en_q <= ParityEnable;
            end
            if (state == IDLE)
                fail_q <= 1'b0;
            else if (state == PARITY && at_chk && ParityError)
                fail_q <= 1'b1;
            else if (state == STOP && at_chk)
                fail_q <= 1'b0;
        end
    end

endmodule
